// File: rtl/masked_cumsum_pkg.sv
// masked_cumsum_pkg
// Shared types and default widths for the masked cumulative-sum row sequencer.
//   state_e    : sequencer FSM states (IDLE / RUN / FLUSH)
//   job_desc_t : latched job descriptor (row length, row count)
//   DEF_*_W    : default widths used as parameter defaults by the design
package masked_cumsum_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 16;
    localparam int DEF_ROWS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_LEN_W-1:0]  row_len;
        logic [DEF_ROWS_W-1:0] num_rows;
    } job_desc_t;

endpackage

// File: rtl/masked_cumsum_acc_stage.sv
// masked_cumsum_acc_stage
// Mask-select + add + clear-on-row-start, followed by a single-entry output
// register with valid/ready.
//   clr            : synchronous accumulator clear (new job)
//   up_valid/ready : element handshake from the sequencer
//   up_data/mask   : element and include flag
//   up_row_first   : element is column 0 (accumulator restarts from zero)
//   up_row_last/up_job_last : flags carried alongside the sum
//   out_*          : registered result beat
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready; a producer holding valid keeps its payload stable until
// that edge.
module masked_cumsum_acc_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_mask,
    input  logic              up_row_first,
    input  logic              up_row_last,
    input  logic              up_job_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_row_last,
    output logic              out_job_last
);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              row_last_q, row_last_d;
    logic              job_last_q, job_last_d;
    logic [DATA_W-1:0] sum;
    logic              fire;

    // Output register can take a new beat when empty or when it is being
    // popped in the same cycle.
    assign up_ready = !valid_q || out_ready;
    assign fire     = up_valid && up_ready;

    // Plain wrap-around add; the top bit carry is intentionally dropped.
    assign sum = (up_row_first ? '0 : acc_q) + (up_mask ? up_data : '0);

    always_comb begin
        acc_d      = acc_q;
        data_d     = data_q;
        valid_d    = valid_q;
        row_last_d = row_last_q;
        job_last_d = job_last_q;
        if (clr) begin
            acc_d = '0;
        end
        if (fire) begin
            acc_d      = sum;
            data_d     = sum;
            valid_d    = 1'b1;
            row_last_d = up_row_last;
            job_last_d = up_job_last;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            row_last_q <= 1'b0;
            job_last_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            row_last_q <= row_last_d;
            job_last_q <= job_last_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_row_last = row_last_q;
    assign out_job_last = job_last_q;

endmodule

// File: rtl/masked_cumsum_seq_ctrl.sv
// masked_cumsum_seq_ctrl
// Row sequencer for the masked cumulative sum. Accepts a job descriptor,
// walks row-major elements, and emits running masked prefix sums that
// restart at every row, tagging row and job ends.
//   cfg_*     : job descriptor handshake (row_len, num_rows), cfg_err pulse
//   in_*      : element stream (data, mask)
//   out_*     : result stream (prefix sum, row_last, job_last)
//   busy      : sequencer not idle
//   dbg_state : current FSM state for observation
//
// Handshake rule: every valid/ready pair transfers on a rising edge where
// both are high; the producer must hold valid and payload until then.
module masked_cumsum_seq_ctrl
    import masked_cumsum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int ROWS_W = DEF_ROWS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LEN_W-1:0]  cfg_row_len,
    input  logic [ROWS_W-1:0] cfg_num_rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_row_last,
    output logic              out_job_last,
    output logic              busy,
    output logic              cfg_err,
    output state_e            dbg_state
);

    state_e            state_q, state_d;
    job_desc_t         job_q, job_d;
    logic [LEN_W-1:0]  col_q, col_d;
    logic [ROWS_W-1:0] row_q, row_d;
    logic              cfg_err_q, cfg_err_d;

    logic acc_clr;
    logic stage_up_valid;
    logic stage_up_ready;
    logic in_fire;
    logic col_last;
    logic row_final;

    assign col_last  = (col_q == LEN_W'(job_q.row_len) - LEN_W'(1));
    assign row_final = (row_q == ROWS_W'(job_q.num_rows) - ROWS_W'(1));

    assign stage_up_valid = in_valid && (state_q == ST_RUN);
    assign in_ready       = (state_q == ST_RUN) && stage_up_ready;
    assign in_fire        = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        job_d     = job_q;
        col_d     = col_q;
        row_d     = row_q;
        cfg_err_d = 1'b0;
        acc_clr   = 1'b0;
        cfg_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (cfg_row_len != '0 && cfg_num_rows != '0) begin
                        job_d.row_len  = DEF_LEN_W'(cfg_row_len);
                        job_d.num_rows = DEF_ROWS_W'(cfg_num_rows);
                        col_d          = '0;
                        row_d          = '0;
                        acc_clr        = 1'b1;
                        state_d        = ST_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (in_fire) begin
                    if (col_last) begin
                        col_d = '0;
                        if (row_final) begin
                            state_d = ST_FLUSH;
                        end else begin
                            row_d = row_q + ROWS_W'(1);
                        end
                    end else begin
                        col_d = col_q + LEN_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                // Wait for the final beat to leave the output register.
                if (out_valid && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            job_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            job_q     <= job_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    masked_cumsum_acc_stage #(
        .DATA_W(DATA_W)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (acc_clr),
        .up_valid    (stage_up_valid),
        .up_ready    (stage_up_ready),
        .up_data     (in_data),
        .up_mask     (in_mask),
        .up_row_first(col_q == '0),
        .up_row_last (col_last),
        .up_job_last (col_last && row_final),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row_last(out_row_last),
        .out_job_last(out_job_last)
    );

    assign busy      = (state_q != ST_IDLE);
    assign cfg_err   = cfg_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_masked_cumsum_seq_ctrl.sv
// Testbench for masked_cumsum_seq_ctrl: directed jobs, a prefix-sum model
// producing expected beats per job, and one compare process on every
// negative clock edge.
module tb_masked_cumsum_seq_ctrl;
    import masked_cumsum_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] data;
        logic         row_last;
        logic         job_last;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [15:0]   cfg_row_len;
    logic [15:0]   cfg_num_rows;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_mask;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_row_last;
    logic          out_job_last;
    logic          busy;
    logic          cfg_err;
    state_e        dbg_state;

    masked_cumsum_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_row_len (cfg_row_len),
        .cfg_num_rows(cfg_num_rows),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mask     (in_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row_last(out_row_last),
        .out_job_last(out_job_last),
        .busy        (busy),
        .cfg_err     (cfg_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_total = 0;
    int            n_pass  = 0;
    beat_t         exp_q[$];
    logic [W-1:0]  got_q[$];
    logic          got_rl_q[$];
    logic [W-1:0]  job_d_q[$];
    logic          job_m_q[$];
    int            stall_left = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Expected beats for a job: running sum per row, restarting at column 0.
    task automatic model_job(input int len, input int rows);
        logic [W-1:0] acc;
        int idx;
        beat_t b;
        idx = 0;
        acc = '0;
        for (int r = 0; r < rows; r++) begin
            acc = '0;
            for (int c = 0; c < len; c++) begin
                if (job_m_q[idx]) acc = acc + job_d_q[idx];
                b.data     = acc;
                b.row_last = (c == len - 1);
                b.job_last = (c == len - 1) && (r == rows - 1);
                exp_q.push_back(b);
                idx++;
            end
        end
    endtask

    // ---------------- out_ready driver (stall injection) ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall_left > 0) begin
                out_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_rl, prev_jl;
    logic         after_job_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold      = 1'b0;
            after_job_last = 1'b0;
        end else begin
            if (after_job_last) begin
                chk("busy_drops_after_last", busy, 1'b0);
                after_job_last = 1'b0;
            end
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_data);
                chk("hold_flags", {out_row_last, out_job_last}, {prev_rl, prev_jl});
            end
            if (out_valid && !out_ready)
                chk("in_ready_stalled", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_row_last", out_row_last, e.row_last);
                    chk("out_job_last", out_job_last, e.job_last);
                    got_q.push_back(out_data);
                    got_rl_q.push_back(out_row_last);
                    if (e.job_last) begin
                        chk("busy_at_last_pop", busy, 1'b1);
                        after_job_last = 1'b1;
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_rl   = out_row_last;
            prev_jl   = out_job_last;
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers are entered at posedge+1 and return at posedge+1.
    task automatic send_cfg(input int len, input int rows);
        bit done;
        done = 0;
        cfg_valid    = 1'b1;
        cfg_row_len  = 16'(len);
        cfg_num_rows = 16'(rows);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (cfg_ready) done = 1;
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        if (!done) chk("cfg_timeout", 1'b0, 1'b1);
    endtask

    task automatic feed_one(input logic [W-1:0] d, input logic m);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("in_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1;
        end
        if (!done) chk("job_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Runs a full job from job_d_q/job_m_q; stall_at < 0 means no stall.
    task automatic run_job(input int len, input int rows, input int stall_at);
        got_q.delete();
        got_rl_q.delete();
        model_job(len, rows);
        send_cfg(len, rows);
        for (int i = 0; i < job_d_q.size(); i++) begin
            if (i == stall_at) stall_left = 3;
            feed_one(job_d_q[i], job_m_q[i]);
        end
        in_valid = 1'b0;
        wait_idle();
    endtask

    task automatic bad_cfg(input int len, input int rows);
        cfg_valid    = 1'b1;
        cfg_row_len  = 16'(len);
        cfg_num_rows = 16'(rows);
        @(negedge clk);
        chk("bad_cfg_ready", cfg_ready, 1'b1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", cfg_err, 1'b1);
        chk("bad_cfg_busy", busy, 1'b0);
        chk("bad_cfg_ready_after", cfg_ready, 1'b1);
        @(negedge clk);
        chk("cfg_err_one_cycle", cfg_err, 1'b0);
        chk("bad_cfg_busy2", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n        = 1'b0;
        cfg_valid    = 1'b0;
        cfg_row_len  = '0;
        cfg_num_rows = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_mask      = 1'b0;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_flags", {out_row_last, out_job_last}, 2'b00);
        #14 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);

        // Pin the model against hand-computed sums.
        job_d_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        job_m_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        model_job(4, 1);
        chk("model_pin_b2", exp_q[1].data, 32'd1);
        chk("model_pin_b4", exp_q[3].data, 32'd8);
        chk("model_pin_jl", exp_q[3].job_last, 1'b1);
        exp_q.delete();

        // Test 1: single row with a masked-off element.
        run_job(4, 1, -1);
        chk("t1_count", got_q.size(), 32'd4);
        if (got_q.size() == 4) begin
            chk("t1_b1", got_q[0], 32'd1);
            chk("t1_b2", got_q[1], 32'd1);
            chk("t1_b3", got_q[2], 32'd4);
            chk("t1_b4", got_q[3], 32'd8);
            chk("t1_row_last", {got_rl_q[0], got_rl_q[1], got_rl_q[2], got_rl_q[3]}, 4'b0001);
        end

        // Test 2: two rows, accumulator restarts at the row boundary.
        job_d_q = '{32'd5, 32'd5, 32'd5, 32'd7, 32'd7, 32'd7};
        job_m_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_job(3, 2, -1);
        chk("t2_count", got_q.size(), 32'd6);
        if (got_q.size() == 6) begin
            chk("t2_b3", got_q[2], 32'd15);
            chk("t2_b4", got_q[3], 32'd7);
            chk("t2_b6", got_q[5], 32'd21);
            chk("t2_row_last", {got_rl_q[0], got_rl_q[1], got_rl_q[2],
                                got_rl_q[3], got_rl_q[4], got_rl_q[5]}, 6'b001001);
        end

        // Test 3: 3-cycle backpressure mid-row, two rows.
        job_d_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd20, 32'd30, 32'd40};
        job_m_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        run_job(4, 2, 2);
        chk("t3_count", got_q.size(), 32'd8);
        if (got_q.size() == 8) begin
            chk("t3_b4", got_q[3], 32'd7);
            chk("t3_b8", got_q[7], 32'd80);
        end

        // Test 4: rejected descriptors, then a normal job.
        bad_cfg(0, 3);
        bad_cfg(2, 0);
        job_d_q = '{32'hFFFF_FFFD, 32'd9};
        job_m_q = '{1'b1, 1'b1};
        run_job(2, 1, -1);
        chk("t4_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) chk("t4_b2", got_q[1], 32'd6);

        // Test 5: signed overflow wraps.
        job_d_q = '{32'h7FFF_FFFF, 32'd1};
        job_m_q = '{1'b1, 1'b1};
        run_job(2, 1, -1);
        if (got_q.size() == 2) begin
            chk("t5_b1", got_q[0], 32'h7FFF_FFFF);
            chk("t5_b2", got_q[1], 32'h8000_0000);
        end else begin
            chk("t5_count", got_q.size(), 32'd2);
        end

        // Test 6: row_len=1, every beat ends a row and equals its masked element.
        job_d_q = '{32'd3, 32'd4, 32'd5};
        job_m_q = '{1'b1, 1'b0, 1'b1};
        run_job(1, 3, -1);
        if (got_q.size() == 3) begin
            chk("t6_data", {got_q[0][7:0], got_q[1][7:0], got_q[2][7:0]}, 24'h030005);
            chk("t6_row_last", {got_rl_q[0], got_rl_q[1], got_rl_q[2]}, 3'b111);
        end else begin
            chk("t6_count", got_q.size(), 32'd3);
        end

        // Test 7: reset after 2 of 4 elements, then a fresh job.
        job_d_q = '{32'd11, 32'd12, 32'd13, 32'd14};
        job_m_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        got_q.delete();
        got_rl_q.delete();
        model_job(4, 1);
        send_cfg(4, 1);
        feed_one(32'd11, 1'b1);
        feed_one(32'd12, 1'b1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, '0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_flags", {out_row_last, out_job_last}, 2'b00);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_cfg_ready", cfg_ready, 1'b1);
        job_d_q = '{32'd10, 32'hFFFF_FFFD};
        job_m_q = '{1'b1, 1'b1};
        run_job(2, 1, -1);
        if (got_q.size() == 2) begin
            chk("t7_b1", got_q[0], 32'd10);
            chk("t7_b2", got_q[1], 32'd7);
        end else begin
            chk("t7_count", got_q.size(), 32'd2);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/masked_cumsum_seq_ctrl.md
Name: masked_cumsum_seq_ctrl

Overview:
- Row sequencer and accumulator controller for the masked cumulative-sum datapath.
- Accepts a job descriptor (row length, row count), then streams row-major elements with a per-element mask.
- Emits running masked prefix sums, clearing the accumulator at every row boundary and marking row/job ends.
- Sits between the tensor streaming front-end and the result writer; one job in flight at a time.

Parameters:
- DATA_W, 32, element and sum width (two's complement, wrap-around arithmetic).
- LEN_W, 16, width of row-length field and column counter.
- ROWS_W, 16, width of row-count field and row counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  descriptor accepted when cfg_valid && cfg_ready.
- cfg_row_len  in  LEN_W  elements per row (dim size along the cumsum axis).
- cfg_num_rows  in  ROWS_W  number of rows in the job.
- in_valid  in  1  element valid.
- in_ready  out  1  element accepted when in_valid && in_ready.
- in_data  in  DATA_W  element value, signed.
- in_mask  in  1  1 = include element in the sum, 0 = contribute zero.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  masked prefix sum up to and including the current element.
- out_row_last  out  1  result is the last column of its row.
- out_job_last  out  1  result is the final element of the job.
- busy  out  1  FSM not in IDLE.
- cfg_err  out  1  one-cycle pulse: descriptor rejected (zero length or zero rows).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid, out_data, out_row_last, out_job_last, busy, cfg_err, counters and accumulator all 0; cfg_ready=1 after reset release.
- FSM states: IDLE, RUN, FLUSH.
- IDLE: cfg_ready=1, in_ready=0.
  - On cfg handshake with row_len!=0 and num_rows!=0: latch both fields, clear col/row counters and accumulator, go to RUN.
  - On cfg handshake with either field 0: cfg_err=1 for one cycle, stay IDLE, nothing latched.
- RUN: cfg_ready=0. in_ready = !out_valid || out_ready (single-entry output register with pass-through on pop).
  - Per accepted element: sum = (col==0 ? 0 : acc) + (in_mask ? in_data : 0), truncated to DATA_W. Register sum into acc and out_data.
  - out_valid=1 on the next cycle: 1-cycle latency, full throughput when out_ready=1.
  - out_row_last = (col==row_len-1). out_job_last = out_row_last && (row==num_rows-1).
  - col increments per element and wraps to 0 at row_len-1, where row increments.
  - Accepting the final element moves the FSM to FLUSH.
- FLUSH: in_ready=0, cfg_ready=0. When out_valid && out_ready: out_valid<=0, go to IDLE.
- Output stability: out_data and flags are held stable while out_valid && !out_ready.
- A masked-off element still produces an output beat, equal to the unchanged running sum.
- Overflow: silent two's-complement wrap; no saturation, no flag.
- row_len=1: every beat has out_row_last=1 and out_data equals the masked element.
- busy = (state != IDLE).
- cfg_valid while busy: ignored, not stored; the upstream must hold it until IDLE.
- rst_n asserted mid-job: immediate return to the reset state; any partial job is discarded with no output.

Decomposition:
- Package masked_cumsum_pkg holds:
  - state enum (IDLE/RUN/FLUSH);
  - default width constants DATA_W/LEN_W/ROWS_W;
  - a job descriptor struct (row_len, num_rows).
- One natural sub-module, masked_cumsum_acc_stage: the mask-select, add, clear-on-row-start logic plus the output holding register with its valid/ready.
- FSM and counters stay in the top.

Test Plan:
- cfg row_len=4, num_rows=1; data 1,2,3,4, mask 1,0,1,1, out_ready=1 -> out_data 1,1,4,8; out_row_last only on beat 4; out_job_last on beat 4; busy drops the cycle after beat 4 pops.
- cfg row_len=3, num_rows=2; data 5,5,5,7,7,7 all masked in -> 5,10,15,7,14,21; out_row_last on beats 3 and 6; accumulator clears at the row boundary.
- Backpressure: hold out_ready=0 for 3 cycles mid-row -> in_ready=0, out_data held constant, no element lost or duplicated; sequence matches the unstalled reference.
- cfg row_len=0 (or num_rows=0) -> cfg_err pulses exactly 1 cycle, busy stays 0, cfg_ready stays 1; a following valid cfg is accepted normally.
- Wrap: row_len=2, data 0x7FFFFFFF, 1, masked in -> out_data 0x7FFFFFFF, 0x80000000.
- Reset asserted after 2 of 4 elements -> all outputs 0 immediately; after release a new job runs cleanly from col 0 with acc 0.
